// File: rtl/seg_scan_decoder_if.sv
// Bundle of the scanned display lines and the decoded frame outputs.
// The driver of the multiplexed display (or a bench) uses the master view;
// the decoder uses the slave view.
interface seg_scan_decoder_if;
  logic [6:0]  segments;      // cathodes, active-low, bit0=a .. bit6=g
  logic [3:0]  anode_active;  // digit enables, active-low, bit0 = rightmost
  logic [15:0] digits;        // last complete frame, digit n in [4n+3:4n]
  logic        frame_valid;   // one-cycle pulse when digits updates
  logic        err;           // one-cycle pulse on an illegal stable input
  logic        stale;         // no valid capture for TIMEOUT cycles

  modport master (
    output segments, anode_active,
    input  digits, frame_valid, err, stale
  );

  modport slave (
    input  segments, anode_active,
    output digits, frame_valid, err, stale
  );
endinterface

// File: rtl/seg_scan_decoder.sv
// Recovers the four BCD digits shown on a scanned 7-segment display by
// sniffing its active-low cathode and anode lines. Each stable dwell is
// evaluated once; a frame is published when all four positions have been
// captured since the previous frame.
module seg_scan_decoder #(
  parameter int STABLE_CYCLES = 4,
  parameter int TIMEOUT       = 400000
) (
  input  logic                clk,
  input  logic                reset,
  seg_scan_decoder_if.slave   bus
);

  localparam int TW = $clog2(TIMEOUT + 1);

  logic [10:0]   r_in_q;
  logic [7:0]    r_stab_cnt;
  logic [3:0]    r_seen;
  logic [15:0]   r_shadow;
  logic [15:0]   r_digits;
  logic          r_frame_valid;
  logic          r_err;
  logic [TW-1:0] r_to_cnt;
  logic          r_stale;

  logic          w_change;
  logic          w_eval;
  logic [3:0]    w_anode;
  logic [6:0]    w_seg;
  logic [3:0]    w_sel;
  logic          w_pos_ok;
  logic          w_seg_ok;
  logic [3:0]    w_val;
  logic          w_capture;
  logic          w_bad;
  logic          w_complete;
  logic [15:0]   w_shadow_next;

  // in_q is about to change on this edge; the counter restarts with the new
  // sample, so a sample first seen at edge k reaches STABLE_CYCLES at edge
  // k+STABLE_CYCLES.
  assign w_change = ({bus.anode_active, bus.segments} != r_in_q);
  assign w_eval   = !w_change && (r_stab_cnt == 8'(STABLE_CYCLES - 1));

  assign w_anode  = r_in_q[10:7];
  assign w_seg    = r_in_q[6:0];
  assign w_sel    = ~w_anode;

  // Exactly one anode low selects a position; all-high is a blanking gap.
  always_comb begin
    w_pos_ok = 1'b0;
    case (w_anode)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: w_pos_ok = 1'b1;
      default:                            w_pos_ok = 1'b0;
    endcase
  end

  // Active-low gfedcba pattern to BCD; anything else is not a digit.
  always_comb begin
    w_seg_ok = 1'b1;
    w_val    = 4'd0;
    case (w_seg)
      7'b1000000: w_val = 4'd0;
      7'b1111001: w_val = 4'd1;
      7'b0100100: w_val = 4'd2;
      7'b0110000: w_val = 4'd3;
      7'b0011001: w_val = 4'd4;
      7'b0010010: w_val = 4'd5;
      7'b0000010: w_val = 4'd6;
      7'b1111000: w_val = 4'd7;
      7'b0000000: w_val = 4'd8;
      7'b0010000: w_val = 4'd9;
      default:    w_seg_ok = 1'b0;
    endcase
  end

  assign w_capture  = w_eval && w_pos_ok && w_seg_ok;
  assign w_bad      = w_eval && (w_anode != 4'hF) && !(w_pos_ok && w_seg_ok);
  assign w_complete = w_capture && ((r_seen | w_sel) == 4'hF);

  // Shadow including a same-cycle capture, so a completing capture lands in
  // the published frame.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_slot
      assign w_shadow_next[4*gi+3:4*gi] =
        (w_capture && w_sel[gi]) ? w_val : r_shadow[4*gi+3:4*gi];
    end
  endgenerate

  // Input sample register and dwell stability counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_in_q     <= '0;
      r_stab_cnt <= '0;
    end else begin
      r_in_q <= {bus.anode_active, bus.segments};
      if (w_change)
        r_stab_cnt <= '0;
      else if (r_stab_cnt != 8'(STABLE_CYCLES))
        r_stab_cnt <= r_stab_cnt + 8'd1;
    end
  end

  // Frame assembly: shadow slots, seen mask, published digits and pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_seen        <= '0;
      r_shadow      <= '0;
      r_digits      <= '0;
      r_frame_valid <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_shadow      <= w_shadow_next;
      r_frame_valid <= w_complete;
      r_err         <= w_bad;
      if (w_complete) begin
        r_digits <= w_shadow_next;
        r_seen   <= '0;
      end else if (w_capture) begin
        r_seen   <= r_seen | w_sel;
      end
    end
  end

  // Staleness watchdog: saturating count of cycles since the last capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_to_cnt <= '0;
      r_stale  <= 1'b0;
    end else if (w_capture) begin
      r_to_cnt <= '0;
      r_stale  <= 1'b0;
    end else if (r_to_cnt != TW'(TIMEOUT)) begin
      r_to_cnt <= r_to_cnt + 1'b1;
      if (r_to_cnt == TW'(TIMEOUT - 1))
        r_stale <= 1'b1;
    end
  end

  assign bus.digits      = r_digits;
  assign bus.frame_valid = r_frame_valid;
  assign bus.err         = r_err;
  assign bus.stale       = r_stale;

endmodule

// File: doc/seg_scan_decoder.md
SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

Interface
REQ-001 Parameter: STABLE_CYCLES, default 4, consecutive identical input samples required before capture (legal range 1..255).
REQ-002 Parameter: TIMEOUT, default 400000, cycles with no valid capture before the stale flag sets.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 segments  input  7  scanned cathodes, active-low, bit0=a ... bit6=g.
REQ-006 anode_active  input  4  digit enables, active-low; bit0 = rightmost digit.
REQ-007 digits  output  16  last complete frame; digit n in bits [4n+3:4n].
REQ-008 frame_valid  output  1  one-cycle pulse when digits is updated.
REQ-009 err  output  1  one-cycle pulse on an illegal stable input.
REQ-010 stale  output  1  level; no valid capture for TIMEOUT cycles.

Function
REQ-011 The block SHALL register {anode_active, segments} once (in_q) and operate only on in_q.
REQ-012 The block SHALL use a stability counter that clears to 0 when in_q differs from its previous value and otherwise increments, saturating at STABLE_CYCLES.
REQ-013 A dwell SHALL be evaluated exactly once, on the edge where the counter reaches STABLE_CYCLES.
- Timing: a new input applied before edge k is evaluated at edge k+STABLE_CYCLES.
- No re-evaluation until in_q changes.
REQ-014 Evaluation rules:
- anode_active = 4'b1111 (blanking gap): ignored; no err, no capture.
- Exactly one bit low: position decode.
- Any other anode value: err pulse; no capture.
REQ-015 Position decode table (segments, gfedcba active-low):
- 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
- 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- Match: value stored in the shadow slot for that position, seen[pos] set.
- Any other pattern: err pulse; shadow slot and seen unchanged.
REQ-016 When a capture makes seen = 4'b1111, the block SHALL:
- copy the shadow, including that same-cycle capture, to digits;
- pulse frame_valid for one cycle;
- clear seen to 0 in the same edge.
REQ-017 Recapturing a position already in seen before the frame completes SHALL overwrite its shadow slot; seen is unchanged.
REQ-018 err and frame_valid SHALL NOT both assert in the same cycle, because one evaluation yields one outcome.
REQ-019 The timeout counter SHALL:
- clear on every valid capture;
- otherwise increment, saturating;
- set stale when it reaches TIMEOUT.
stale SHALL clear on the edge of the next valid capture.
REQ-020 All outputs SHALL be driven directly from flops.

Reset
REQ-021 While reset = 0, the block SHALL immediately force all of the following to 0: in_q, counters, seen, shadow, digits, frame_valid, err, stale.
REQ-022 Reset deassertion mid-dwell SHALL restart stability counting from zero; no partial frame survives reset.
REQ-023 The first frame_valid after reset SHALL require all four positions to be freshly captured.

Verification
REQ-024 Nominal scan: dwell 10 cycles per position, apply 1,2,3,4 to anodes 1110,1101,1011,0111 -> digits = 16'h4321, frame_valid pulses once, 4 cycles after the last dwell starts.
REQ-025 Glitch filter, STABLE_CYCLES=4: pattern held for 3 cycles, then changed -> no capture, no err, seen unchanged.
REQ-026 Illegal inputs:
- anode = 1100 held for 6 cycles -> single err pulse.
- segments = 1111111 on anode 1110 -> single err pulse; no frame completes.
REQ-027 Gaps and overwrite:
- 1111 gaps between digits -> no err; frame still completes.
- Position 0 recaptured as 7 before frame completion -> digits[3:0] = 7.
REQ-028 Timeout, TIMEOUT=50: hold inputs at 1111 -> stale = 1 at cycle 50; one valid capture -> stale = 0.
REQ-029 Reset mid-frame: capture 3 positions, pulse reset low asynchronously between edges -> outputs 0 at once; a 4th capture alone produces no frame_valid.
